// File: rtl/cv32e40s_obi_integrity_responder_pkg.sv
// Shared integrity encodings for the OBI responder shim: address-phase checksum,
// response checksum and the in-order response FIFO entry.
package cv32e40s_obi_integrity_responder_pkg;

  typedef struct packed {
    logic is_local;   // 1: request failed integrity, answered locally with an error
  } obi_resp_fifo_t;

  // achk[3:0] per address byte, achk[4] over {we,be}, achk[8:5] per write-data byte
  function automatic logic [8:0] calc_achk(input logic [31:0] addr,
                                           input logic        we,
                                           input logic [3:0]  be,
                                           input logic [31:0] wdata);
    logic [8:0] chk;
    for (int k = 0; k < 4; k++) begin
      chk[k]   = ^addr[8*k +: 8];
      chk[5+k] = ^wdata[8*k +: 8];
    end
    chk[4] = ^{we, be};
    return chk;
  endfunction

  function automatic logic [4:0] calc_rchk(input logic [31:0] rdata, input logic err);
    logic [4:0] chk;
    for (int k = 0; k < 4; k++) chk[k] = ^rdata[8*k +: 8];
    chk[4] = err;
    return chk;
  endfunction

endpackage

// File: rtl/cv32e40s_obi_integrity_responder_if.sv
// Integrity-enabled OBI bus between the core initiator and the responder shim.
interface cv32e40s_obi_integrity_responder_if;
  logic        req;
  logic        reqpar;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [8:0]  achk;
  logic        gnt;
  logic        gntpar;
  logic        rvalid;
  logic        rvalidpar;
  logic [31:0] rdata;
  logic        err;
  logic [4:0]  rchk;

  modport master (
    output req, reqpar, addr, we, be, wdata, achk,
    input  gnt, gntpar, rvalid, rvalidpar, rdata, err, rchk
  );

  modport slave (
    input  req, reqpar, addr, we, be, wdata, achk,
    output gnt, gntpar, rvalid, rvalidpar, rdata, err, rchk
  );
endinterface

// File: rtl/cv32e40s_obi_resp_fifo.sv
// Circular FIFO holding one entry per granted, not yet answered OBI transaction.
module cv32e40s_obi_resp_fifo
  import cv32e40s_obi_integrity_responder_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  obi_resp_fifo_t push_data,
  input  logic           pop,
  output obi_resp_fifo_t head,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  obi_resp_fifo_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head = mem_q[rptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/cv32e40s_obi_integrity_responder.sv
// Responder-side OBI integrity shim: checks reqpar/achk, generates gntpar/rvalidpar/rchk,
// and answers integrity-failing requests locally with an in-order error response.
module cv32e40s_obi_integrity_responder
  import cv32e40s_obi_integrity_responder_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_W          = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  cv32e40s_obi_integrity_responder_if.slave obi,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        achk_err_o,
  output logic        protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [8:0]        achk_exp, achk_mask;
  logic              chk_err, space, gnt;
  logic              rvalid, err, protocol_err;
  logic [DATA_W-1:0] rdata;
  logic [CNT_W-1:0]  cnt;
  obi_resp_fifo_t    head, push_entry;
  logic              achk_err_q;

  // Write-data checksum bits only carry meaning on writes
  always_comb begin
    achk_exp  = calc_achk(obi.addr, obi.we, obi.be, obi.wdata);
    achk_mask = obi.we ? 9'h1FF : 9'h01F;
    chk_err   = (|((obi.achk ^ achk_exp) & achk_mask)) || (obi.reqpar != ~obi.req);
    space     = cnt < CNT_W'(MAX_OUTSTANDING);
  end

  // A failing request is still granted (and answered locally) but never reaches the backend
  assign gnt        = obi.req && space && (chk_err || mem_gnt_i);
  assign mem_req_o  = obi.req && space && !chk_err;
  assign push_entry = '{is_local: chk_err};

  cv32e40s_obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt),
    .push_data (push_entry),
    .pop       (rvalid),
    .head      (head),
    .cnt       (cnt)
  );

  // Backend responses are only legal when a forwarded transaction sits at the head
  always_comb begin
    rvalid       = 1'b0;
    rdata        = '0;
    err          = 1'b0;
    protocol_err = 1'b0;
    if (cnt == '0) begin
      protocol_err = mem_rvalid_i;
    end else if (head.is_local) begin
      rvalid       = 1'b1;
      err          = 1'b1;
      protocol_err = mem_rvalid_i;
    end else begin
      rvalid = mem_rvalid_i;
      rdata  = mem_rdata_i;
      err    = mem_err_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) achk_err_q <= 1'b0;
    else        achk_err_q <= gnt && chk_err;
  end

  assign obi.gnt        = gnt;
  assign obi.gntpar     = ~gnt;
  assign obi.rvalid     = rvalid;
  assign obi.rvalidpar  = ~rvalid;
  assign obi.rdata      = rdata;
  assign obi.err        = err;
  assign obi.rchk       = calc_rchk(rdata, err);
  assign achk_err_o     = achk_err_q;
  assign protocol_err_o = protocol_err;

endmodule
